// File: rtl/display_mux_ctrl_if.sv
// Bundle between the display multiplexer and its neighbours: run enable and live
// digits in; decoder select, frame-latched digits, anode enables and frame pulse out.
interface display_mux_ctrl_if;
   logic       en;
   logic [3:0] s1_in;
   logic [3:0] s2_in;
   logic       current_hex;
   logic [3:0] s1;
   logic [3:0] s2;
   logic       an1;
   logic       an2;
   logic       frame_tick;

   modport master (
      output en, s1_in, s2_in,
      input  current_hex, s1, s2, an1, an2, frame_tick
   );

   modport slave (
      input  en, s1_in, s2_in,
      output current_hex, s1, s2, an1, an2, frame_tick
   );
endinterface

// File: rtl/display_mux_ctrl.sv
// Dual-digit display time-multiplexer: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 with
// dead time between digits and once-per-frame digit snapshots.
module display_mux_ctrl #(
   parameter int DIV_COUNT    = 2500,
   parameter int BLANK_CYCLES = 250
) (
   input  logic               clk,
   input  logic               reset,
   display_mux_ctrl_if.slave  bus
);
   localparam int MAX_N = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
   localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_COUNT - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   localparam logic [1:0] SHOW0  = 2'd0;
   localparam logic [1:0] BLANK0 = 2'd1;
   localparam logic [1:0] SHOW1  = 2'd2;
   localparam logic [1:0] BLANK1 = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_next_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_last;
   logic          w_slot_end;

   always_comb begin
      w_last       = ((r_state == SHOW0) || (r_state == SHOW1)) ? DIV_LAST : BLANK_LAST;
      w_slot_end   = bus.en && (r_cnt == w_last);
      w_next_state = r_state;
      case (r_state)
         SHOW0:   w_next_state = BLANK0;
         BLANK0:  w_next_state = SHOW1;
         SHOW1:   w_next_state = BLANK1;
         default: w_next_state = SHOW0;
      endcase
   end

   // Reset lands in BLANK1 so the first frame starts cleanly after one blank slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= BLANK1;
         r_cnt          <= '0;
         bus.s1         <= 4'h0;
         bus.s2         <= 4'h0;
         bus.frame_tick <= 1'b0;
      end else begin
         bus.frame_tick <= 1'b0;
         if (w_slot_end) begin
            r_cnt   <= '0;
            r_state <= w_next_state;
            if (r_state == BLANK1) begin
               bus.s1         <= bus.s1_in;
               bus.s2         <= bus.s2_in;
               bus.frame_tick <= 1'b1;
            end
         end else if (bus.en) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Select flips on blank entry so the decoder settles before the next anode lights.
   assign bus.current_hex = (r_state == BLANK0) || (r_state == SHOW1);
   assign bus.an1         = ~(bus.en && (r_state == SHOW0));
   assign bus.an2         = ~(bus.en && (r_state == SHOW1));
endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed table-driven bench for display_mux_ctrl (4/2 timing) plus a 1/1 timing instance.
module tb_display_mux_ctrl;
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   always #5 clk = ~clk;

   display_mux_ctrl_if bus_a ();
   display_mux_ctrl_if bus_b ();

   display_mux_ctrl #(.DIV_COUNT(4), .BLANK_CYCLES(2)) u_dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a)
   );

   display_mux_ctrl #(.DIV_COUNT(1), .BLANK_CYCLES(1)) u_dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b)
   );

   // expected = {an1, an2, current_hex, s1, s2, frame_tick}
   typedef struct {
      logic        en;
      logic [3:0]  s1i;
      logic [3:0]  s2i;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_vec;
   int   n_err;
   logic prev_hex;

   function automatic logic [11:0] act_a();
      return {bus_a.an1, bus_a.an2, bus_a.current_hex, bus_a.s1, bus_a.s2, bus_a.frame_tick};
   endfunction

   function automatic logic [11:0] act_b();
      return {bus_b.an1, bus_b.an2, bus_b.current_hex, bus_b.s1, bus_b.s2, bus_b.frame_tick};
   endfunction

   task automatic add(input int n, input logic e, input logic [3:0] a, input logic [3:0] b,
                      input logic an1, input logic an2, input logic hx,
                      input logic [3:0] x, input logic [3:0] y, input logic tk);
      vec_t v;
      v.en  = e;
      v.s1i = a;
      v.s2i = b;
      v.exp = {an1, an2, hx, x, y, tk};
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got an1=%b an2=%b hex=%b s1=%h s2=%h tick=%b, required an1=%b an2=%b hex=%b s1=%h s2=%h tick=%b",
                  name, act[11], act[10], act[9], act[8:5], act[4:1], act[0],
                  exp[11], exp[10], exp[9], exp[8:5], exp[4:1], exp[0]);
      end else begin
         $display("ok   %s: an1=%b an2=%b hex=%b s1=%h s2=%h tick=%b",
                  name, act[11], act[10], act[9], act[8:5], act[4:1], act[0]);
      end
   endtask

   task automatic run_rows(input int first, input int last, input string tag);
      for (int i = first; i <= last; i++) begin
         bus_a.en    = tbl[i].en;
         bus_a.s1_in = tbl[i].s1i;
         bus_a.s2_in = tbl[i].s2i;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("%s v%0d", tag, i + 1), act_a(), tbl[i].exp);
      end
   endtask

   // Anode exclusivity and select-change-only-while-dark, every cycle on instance A.
   always @(negedge clk) begin
      if (rst_a) begin
         prev_hex = 1'b0;
      end else begin
         if (!bus_a.an1 && !bus_a.an2) begin
            n_err++;
            $display("FAIL anode_overlap: got an1=%b an2=%b, required not both 0", bus_a.an1, bus_a.an2);
         end
         if ((bus_a.current_hex !== prev_hex) && !(bus_a.an1 && bus_a.an2)) begin
            n_err++;
            $display("FAIL hex_toggle_lit: got hex %b->%b with an1=%b an2=%b, required both anodes 1",
                     prev_hex, bus_a.current_hex, bus_a.an1, bus_a.an2);
         end
         prev_hex = bus_a.current_hex;
      end
   end

   initial begin
      logic [11:0] rst_exp;
      logic [11:0] exp_b;
      logic [3:0]  s1e;
      logic [3:0]  s2e;
      int          ph;

      n_vec = 0;
      n_err = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.en = 1'b1; bus_a.s1_in = 4'd4; bus_a.s2_in = 4'd5;
      bus_b.en = 1'b1; bus_b.s1_in = 4'd3; bus_b.s2_in = 4'd6;
      rst_exp = {1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0};

      // Startup, frame 1 (s1_in=4, s2_in=5)
      add(1, 1, 4, 5,   1, 1, 0,   4'd0, 4'd0, 0);
      add(1, 1, 4, 5,   0, 1, 0,   4'd4, 4'd5, 1);
      add(3, 1, 4, 5,   0, 1, 0,   4'd4, 4'd5, 0);
      add(2, 1, 4, 5,   1, 1, 1,   4'd4, 4'd5, 0);
      add(4, 1, 4, 5,   1, 0, 1,   4'd4, 4'd5, 0);
      add(2, 1, 8, 5,   1, 1, 0,   4'd4, 4'd5, 0);
      // Frame 2 with s1=8; s1_in moves to 13 mid-SHOW1
      add(1, 1, 8, 5,   0, 1, 0,   4'd8, 4'd5, 1);
      add(3, 1, 8, 5,   0, 1, 0,   4'd8, 4'd5, 0);
      add(2, 1, 8, 5,   1, 1, 1,   4'd8, 4'd5, 0);
      add(1, 1, 8, 5,   1, 0, 1,   4'd8, 4'd5, 0);
      add(3, 1, 13, 5,  1, 0, 1,   4'd8, 4'd5, 0);
      add(2, 1, 13, 5,  1, 1, 0,   4'd8, 4'd5, 0);
      // Frame 3; one-cycle glitch just before the snapshot edge
      add(1, 1, 13, 5,  0, 1, 0,   4'd13, 4'd5, 1);
      add(3, 1, 13, 5,  0, 1, 0,   4'd13, 4'd5, 0);
      add(2, 1, 13, 5,  1, 1, 1,   4'd13, 4'd5, 0);
      add(4, 1, 13, 5,  1, 0, 1,   4'd13, 4'd5, 0);
      add(1, 1, 13, 5,  1, 1, 0,   4'd13, 4'd5, 0);
      add(1, 1, 2, 7,   1, 1, 0,   4'd13, 4'd5, 0);
      // Frame 4; en low for 5 cycles in SHOW1 at counter 2
      add(1, 1, 13, 9,  0, 1, 0,   4'd13, 4'd9, 1);
      add(3, 1, 13, 9,  0, 1, 0,   4'd13, 4'd9, 0);
      add(2, 1, 13, 9,  1, 1, 1,   4'd13, 4'd9, 0);
      add(3, 1, 13, 9,  1, 0, 1,   4'd13, 4'd9, 0);
      add(5, 0, 13, 9,  1, 1, 1,   4'd13, 4'd9, 0);
      add(1, 1, 13, 9,  1, 0, 1,   4'd13, 4'd9, 0);
      add(2, 1, 13, 9,  1, 1, 0,   4'd13, 4'd9, 0);
      // Frame 5 (stretched by 5), then frame 6 picks up s1=12
      add(1, 1, 13, 9,  0, 1, 0,   4'd13, 4'd9, 1);
      add(3, 1, 12, 9,  0, 1, 0,   4'd13, 4'd9, 0);
      add(2, 1, 12, 9,  1, 1, 1,   4'd13, 4'd9, 0);
      add(4, 1, 12, 9,  1, 0, 1,   4'd13, 4'd9, 0);
      add(2, 1, 12, 9,  1, 1, 0,   4'd13, 4'd9, 0);
      add(1, 1, 12, 9,  0, 1, 0,   4'd12, 4'd9, 1);
      add(1, 1, 12, 9,  0, 1, 0,   4'd12, 4'd9, 0);

      repeat (2) @(negedge clk);
      check("A in_reset", act_a(), rst_exp);
      rst_a = 1'b0;
      check("A cycle1", act_a(), rst_exp);
      run_rows(0, tbl.size() - 1, "A");

      // Asynchronous reset between edges while SHOW0 shows s1=12
      #2 rst_a = 1'b1;
      #1 check("A async_reset", act_a(), rst_exp);
      @(negedge clk);
      @(negedge clk);
      bus_a.en = 1'b1; bus_a.s1_in = 4'd4; bus_a.s2_in = 4'd5;
      rst_a = 1'b0;
      check("A restart cycle1", act_a(), rst_exp);
      run_rows(0, 12, "A restart");

      // DIV_COUNT=1, BLANK_CYCLES=1: period 4, each anode low one cycle per frame
      check("B in_reset", act_b(), rst_exp);
      rst_b = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) begin
            @(posedge clk);
            @(negedge clk);
         end
         ph  = (k - 1) % 4;
         s1e = (k >= 2) ? 4'd3 : 4'd0;
         s2e = (k >= 2) ? 4'd6 : 4'd0;
         case (ph)
            0:       exp_b = {1'b1, 1'b1, 1'b0, s1e, s2e, 1'b0};
            1:       exp_b = {1'b0, 1'b1, 1'b0, s1e, s2e, 1'b1};
            2:       exp_b = {1'b1, 1'b1, 1'b1, s1e, s2e, 1'b0};
            default: exp_b = {1'b1, 1'b0, 1'b1, s1e, s2e, 1'b0};
         endcase
         check($sformatf("B cycle%0d", k), act_b(), exp_b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
